// File: rtl/dds_key_ctrl.sv
// dds_key_ctrl: front-panel key events to DDS tuning word, step size and waveform select
module dds_key_ctrl #(
  parameter int          FW         = 32,
  parameter int unsigned HOLD_CYC   = 25_000_000,
  parameter int unsigned REPEAT_CYC = 5_000_000,
  parameter int unsigned STEP_BASE  = 86,
  parameter int unsigned FREQ_INIT  = 85_899_346,
  parameter int unsigned FREQ_MIN   = 0,
  parameter int unsigned FREQ_MAX   = 2_147_483_647
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_up_n,
  input  logic          key_down_n,
  input  logic          key_step_n,
  input  logic          key_wave_n,
  output logic [FW-1:0] freq_word,
  output logic [1:0]    step_sel,
  output logic [1:0]    wave_sel,
  output logic          update
);
  localparam int CW = $clog2((HOLD_CYC > REPEAT_CYC ? HOLD_CYC : REPEAT_CYC) + 1);
  localparam logic [FW:0] S0 = (FW+1)'(STEP_BASE);
  localparam logic [FW:0] S1 = (FW+1)'(STEP_BASE * 10);
  localparam logic [FW:0] S2 = (FW+1)'(STEP_BASE * 100);
  localparam logic [FW:0] S3 = (FW+1)'(STEP_BASE * 1000);
  localparam logic [FW:0] MAXW = (FW+1)'(FREQ_MAX);
  localparam logic [FW:0] MINW = (FW+1)'(FREQ_MIN);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t st;
  logic dir;
  logic [CW-1:0] cnt;
  logic [3:0] keys, smp, prv, arm, press;
  logic both, act_lo, start, rep, go, go_up;
  logic [FW:0] step, sum;
  logic [FW-1:0] up_v, dn_v, nf;
  assign keys = {key_wave_n, key_step_n, key_down_n, key_up_n};
  // a press is a falling sample edge on a key that has been seen released since reset
  always_comb begin
    press = arm & ~smp & prv;
    both = ~smp[0] & ~smp[1];
    act_lo = dir ? ~smp[0] : ~smp[1];
    start = st == IDLE && !both && (press[0] || press[1]);
    rep = st != IDLE && act_lo && !both && cnt == '0;
    go = start || rep;
    go_up = start ? press[0] : dir;
    step = step_sel == 2'd0 ? S0 : step_sel == 2'd1 ? S1 : step_sel == 2'd2 ? S2 : S3;
    sum = {1'b0, freq_word} + step;
    up_v = sum > MAXW ? MAXW[FW-1:0] : sum[FW-1:0];
    dn_v = {1'b0, freq_word} < MINW + step ? MINW[FW-1:0] : freq_word - step[FW-1:0];
    nf = go_up ? up_v : dn_v;
  end
  // key sampling, arming, selects, tuning word and the hold/repeat FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= '1;
      prv <= '1;
      arm <= '0;
      st <= IDLE;
      dir <= 1'b0;
      cnt <= '0;
      freq_word <= FREQ_INIT[FW-1:0];
      step_sel <= 2'd0;
      wave_sel <= 2'd0;
      update <= 1'b0;
    end else begin
      smp <= keys;
      prv <= smp;
      arm <= arm | keys;
      if (press[2]) step_sel <= step_sel + 2'd1;
      if (press[3]) wave_sel <= wave_sel + 2'd1;
      update <= press[3] || (go && nf != freq_word);
      if (go) freq_word <= nf;
      if (start) begin
        st <= HOLD;
        dir <= press[0];
        cnt <= CW'(HOLD_CYC - 1);
      end else if (st != IDLE && (!act_lo || both)) begin
        st <= IDLE;
        cnt <= '0;
      end else if (rep) begin
        st <= REPEAT;
        cnt <= CW'(REPEAT_CYC - 1);
      end else if (st != IDLE) begin
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule
